// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing generator: default SVGA 800x600@60 geometry
// (40 MHz pclk), the derived sync/blank boundaries and the counter width.
package vga_timing_pkg;

  localparam int CNT_W = 11;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 40;
  localparam int H_SYNC_DEF   = 128;
  localparam int H_BP_DEF     = 88;
  localparam int V_ACTIVE_DEF = 600;
  localparam int V_FP_DEF     = 1;
  localparam int V_SYNC_DEF   = 4;
  localparam int V_BP_DEF     = 23;

  localparam int H_TOTAL  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int HS_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int HS_END   = HS_START + H_SYNC_DEF;
  localparam int VS_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int VS_END   = VS_START + V_SYNC_DEF;

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One timing axis: wrapping position counter with registered blank/sync decode.
// Flags decode the next count so they land in the same cycle as the count they describe.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = H_TOTAL,
  parameter int ACTIVE     = H_ACTIVE_DEF,
  parameter int SYNC_START = HS_START,
  parameter int SYNC_END   = HS_END,
  parameter bit SYNC_POL   = 1'b1
) (
  input  logic pclk,
  input  logic rst,
  input  logic en_i,
  output cnt_t cnt_o,
  output logic blnk_o,
  output logic sync_o,
  output logic wrap_o
);

  localparam cnt_t LAST = cnt_t'(TOTAL - 1);
  localparam cnt_t ACT  = cnt_t'(ACTIVE);
  localparam cnt_t SS   = cnt_t'(SYNC_START);
  localparam cnt_t SE   = cnt_t'(SYNC_END);

  cnt_t cnt_q, cnt_d;
  logic blnk_q, blnk_d;
  logic sync_q, sync_d;

  assign wrap_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + cnt_t'(1);
    blnk_d = (cnt_d >= ACT);
    sync_d = ((cnt_d >= SS) && (cnt_d < SE)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      cnt_q  <= '0;
      blnk_q <= 1'b0;
      sync_q <= ~SYNC_POL;
    end else begin
      cnt_q  <= cnt_d;
      blnk_q <= blnk_d;
      sync_q <= sync_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign blnk_o = blnk_q;
  assign sync_o = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing bus source (hcount/vcount/hsync/hblnk/vsync/vblnk), all outputs registered.
// Optional VGA_TIMING_FRAME_CNT_EN adds a frame-start pulse and a 16-bit frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic             pclk,
  input  logic             rst,
  output logic [CNT_W-1:0] hcount_out,
  output logic             hsync_out,
  output logic             hblnk_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             vsync_out,
  output logic             vblnk_out
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic             frame_start_out,
  output logic [15:0]      frame_cnt_out
`endif
);

  localparam int H_LEN = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_LEN = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO = H_ACTIVE + H_FP;
  localparam int VS_LO = V_ACTIVE + V_FP;

  logic h_wrap;
  logic v_wrap;

  vga_axis_counter #(
    .TOTAL(H_LEN), .ACTIVE(H_ACTIVE), .SYNC_START(HS_LO),
    .SYNC_END(HS_LO + H_SYNC), .SYNC_POL(SYNC_POL)
  ) u_h (
    .pclk(pclk), .rst(rst), .en_i(1'b1),
    .cnt_o(hcount_out), .blnk_o(hblnk_out), .sync_o(hsync_out), .wrap_o(h_wrap)
  );

  // Vertical advances only on the horizontal wrap, so vsync moves on line boundaries.
  vga_axis_counter #(
    .TOTAL(V_LEN), .ACTIVE(V_ACTIVE), .SYNC_START(VS_LO),
    .SYNC_END(VS_LO + V_SYNC), .SYNC_POL(SYNC_POL)
  ) u_v (
    .pclk(pclk), .rst(rst), .en_i(h_wrap),
    .cnt_o(vcount_out), .blnk_o(vblnk_out), .sync_o(vsync_out), .wrap_o(v_wrap)
  );

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic        fs_q;
  logic [15:0] fc_q, fc_d;

  // v_wrap is gated by h_wrap, so it marks the (last,last) -> (0,0) edge only.
  assign fc_d = v_wrap ? fc_q + 16'd1 : fc_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      fs_q <= 1'b0;
      fc_q <= '0;
    end else begin
      fs_q <= v_wrap;
      fc_q <= fc_d;
    end
  end

  assign frame_start_out = fs_q;
  assign frame_cnt_out   = fc_q;
`else
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a small-geometry negative-polarity instance plus a default SVGA
// instance, both checked every cycle against a position-from-cycle-count model.
module tb_vga_timing_gen;

  typedef struct {
    int unsigned ha, hf, hs, hb, va, vf, vs, vb;
    bit pol;
  } geom_t;

  typedef struct {
    int unsigned h, v, fc;
    bit hs, hb, vs, vb, fs;
  } exp_t;

  localparam geom_t GS = '{ha:20, hf:3, hs:5, hb:4, va:10, vf:1, vs:2, vb:3, pol:1'b0};
  localparam geom_t GD = '{ha:800, hf:40, hs:128, hb:88, va:600, vf:1, vs:4, vb:23, pol:1'b1};

  logic        pclk;
  logic        rst;
  logic [10:0] hc_s, vc_s, hc_d, vc_d;
  logic        hs_s, hb_s, vs_s, vb_s, hs_d, hb_d, vs_d, vb_d;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic        fs_s, fs_d;
  logic [15:0] fc_s, fc_d;
`endif

  vga_timing_gen #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) u_small (
    .pclk(pclk), .rst(rst),
    .hcount_out(hc_s), .hsync_out(hs_s), .hblnk_out(hb_s),
    .vcount_out(vc_s), .vsync_out(vs_s), .vblnk_out(vb_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_start_out(fs_s), .frame_cnt_out(fc_s)
`endif
  );

  vga_timing_gen u_dflt (
    .pclk(pclk), .rst(rst),
    .hcount_out(hc_d), .hsync_out(hs_d), .hblnk_out(hb_d),
    .vcount_out(vc_d), .vsync_out(vs_d), .vblnk_out(vb_d)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_start_out(fs_d), .frame_cnt_out(fc_d)
`endif
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned t = 0;
  bit          armed = 1'b0;
  exp_t        q_s[$];
  exp_t        q_d[$];

  // t = cycles since the last reset edge; the position is just t folded into the frame.
  function automatic exp_t model(geom_t g, int unsigned tt);
    exp_t e;
    int unsigned ht  = g.ha + g.hf + g.hs + g.hb;
    int unsigned vt  = g.va + g.vf + g.vs + g.vb;
    int unsigned per = ht * vt;
    e.h  = tt % ht;
    e.v  = (tt / ht) % vt;
    e.hb = (e.h >= g.ha);
    e.vb = (e.v >= g.va);
    e.hs = (e.h >= g.ha + g.hf && e.h < g.ha + g.hf + g.hs) ? g.pol : !g.pol;
    e.vs = (e.v >= g.va + g.vf && e.v < g.va + g.vf + g.vs) ? g.pol : !g.pol;
    e.fs = (tt != 0) && (tt % per == 0);
    e.fc = (tt / per) % 65536;
    return e;
  endfunction

  task automatic chk(string name, int unsigned act, int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0d required=%0d", name, t, act, req);
    end
  endtask

  task automatic cycle(bit r);
    @(negedge pclk);
    rst = r;
    t   = r ? 0 : t + 1;
    q_s.push_back(model(GS, t));
    q_d.push_back(model(GD, t));
    armed = 1'b1;
  endtask

  // Monitor: one output position per cycle from each instance.
  initial begin
    exp_t e;
    forever begin
      @(posedge pclk);
      #1;
      if (armed) begin
        if (q_s.size() == 0 || q_d.size() == 0) begin
          chk("sb_empty", 0, 1);
        end else begin
          e = q_s.pop_front();
          chk("s_hcount", hc_s, e.h);
          chk("s_vcount", vc_s, e.v);
          chk("s_hsync",  hs_s, e.hs);
          chk("s_hblnk",  hb_s, e.hb);
          chk("s_vsync",  vs_s, e.vs);
          chk("s_vblnk",  vb_s, e.vb);
`ifdef VGA_TIMING_FRAME_CNT_EN
          chk("s_fstart", fs_s, e.fs);
          chk("s_fcnt",   fc_s, e.fc);
`endif
          e = q_d.pop_front();
          chk("d_hcount", hc_d, e.h);
          chk("d_vcount", vc_d, e.v);
          chk("d_hsync",  hs_d, e.hs);
          chk("d_hblnk",  hb_d, e.hb);
          chk("d_vsync",  vs_d, e.vs);
          chk("d_vblnk",  vb_d, e.vb);
`ifdef VGA_TIMING_FRAME_CNT_EN
          chk("d_fstart", fs_d, e.fs);
          chk("d_fcnt",   fc_d, e.fc);
`endif
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) cycle(1'b1);
    // Mid-frame reset with the small instance in hsync/hblank of line 7.
    repeat (7 * 32 + 25) cycle(1'b0);
    cycle(1'b1);
    // Uninterrupted run: 4 small frames, 2 default lines.
    repeat (2200) cycle(1'b0);
    repeat (12) begin
      n = int'($urandom_range(700, 1));
      repeat (n) cycle(1'b0);
      n = int'($urandom_range(3, 1));
      repeat (n) cycle(1'b1);
    end
    repeat (1100) cycle(1'b0);
    @(posedge pclk);
    #2;
    if (q_s.size() != 0 || q_d.size() != 0) chk("sb_drain", q_s.size() + q_d.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source of the VGA timing bus: hcount, vcount, hsync, hblnk, vsync, vblnk.
- Every draw stage in the pixel pipeline consumes this bus, latches it and forwards it unchanged alongside rgb.
- Default geometry is SVGA 800x600@60 Hz with a 40 MHz pclk; all geometry values are parameters.
- Sits at the head of the display chain, ahead of the background/draw stages.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync pulse width (pixels)
- H_BP, 88, horizontal back porch (pixels); H_TOTAL = sum of the four = 1056
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync pulse width (lines)
- V_BP, 23, vertical back porch (lines); V_TOTAL = 628
- SYNC_POL, 1, active level of hsync/vsync (1 = positive)

Ports:
- pclk  in  1  pixel clock
- rst  in  1  reset
- hcount_out  out  11  horizontal position, 0..H_TOTAL-1
- hsync_out  out  1  horizontal sync at SYNC_POL level
- hblnk_out  out  1  high outside the active horizontal region
- vcount_out  out  11  vertical position, 0..V_TOTAL-1
- vsync_out  out  1  vertical sync at SYNC_POL level
- vblnk_out  out  1  high outside the active vertical region
- Interface rule: reset rst, synchronous, active-high; clock pclk.

Behaviour:
- All six outputs are registered. In every cycle they describe the same (h, v) position; no output may skew relative to another.
- Reset (rst high at a pclk edge):
  - hcount_out = 0, vcount_out = 0, hblnk_out = 0, vblnk_out = 0
  - hsync_out = vsync_out = ~SYNC_POL (inactive)
  - Reset is honoured mid-line and mid-frame: the next cycle after rst deasserts presents position (0,0) again.
- Counting:
  - hcount increments by 1 every pclk. At H_TOTAL-1 it wraps to 0.
  - vcount holds for the whole line and increments only on the h wrap. At V_TOTAL-1 it wraps to 0, so (1055,627) -> (0,0).
- Decode, computed from the next counter values so the registered flags align with the registered counts:
  - hblnk = (h >= H_ACTIVE)
  - hsync active = (h >= H_ACTIVE+H_FP) && (h < H_ACTIVE+H_FP+H_SYNC), i.e. 840..967 at defaults
  - vblnk = (v >= V_ACTIVE)
  - vsync active = (v >= V_ACTIVE+V_FP) && (v < V_ACTIVE+V_FP+V_SYNC), i.e. lines 601..604 at defaults
  - vsync changes only at h = 0, i.e. on line boundaries.
- Latency: first valid position (0,0) appears on the first edge after reset release. Steady state is one position per cycle with no bubbles.
- Width rule: counters are 11-bit unsigned; H_TOTAL and V_TOTAL must be <= 2048. Comparisons are unsigned.
- Period: H_TOTAL*V_TOTAL = 663168 cycles per frame at defaults.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined: adds two outputs.
  - frame_start_out  out  1: a one-cycle pulse aligned with position (0,0). It does not fire on the first cycle after reset.
  - frame_cnt_out  out  16: increments together with each frame_start pulse and wraps 65535 -> 0. Reset value is 0.
- Undefined: neither port exists and no extra logic is built; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - the default SVGA geometry constants
  - derived constants H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END
  - the 11-bit count width constant
- Sub-module vga_axis_counter is natural:
  - a parameterised counter plus blank/sync decoder with an advance-enable input and a wrap output
  - instantiated twice: horizontal with enable tied high; vertical with enable = horizontal wrap.

Test Plan:
- Reset, then release -> first cycle shows hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=vsync=0; next cycle hcount=1.
- Run one line -> hblnk rises exactly at hcount=800; hsync high for hcount 840..967 (128 cycles); hcount 1055 -> 0 with vcount 0 -> 1 on the same edge.
- Run one full frame -> vblnk high for vcount 600..627; vsync high for 4 lines (601..604), changing only at hcount=0; (1055,627) -> (0,0); frame length is 663168 cycles.
- Assert rst for 1 cycle at position (500,300) -> next output (0,0) with all flags inactive, then normal counting resumes.
- Sweep per cycle over 2 frames -> each flag always matches its decode of the concurrently output hcount/vcount (no skew).
- With VGA_TIMING_FRAME_CNT_EN and SYNC_POL=0 -> frame_start pulses exactly at each (0,0) after the first frame; frame_cnt reads 1, 2 after 2 frames; syncs idle high and go low during their pulses.
